// File: rtl/divider_seq_ctrl.sv
// divider_seq_ctrl: sequential MIPS DIV/DIVU unit for the EX stage.
// Operands are accepted on a valid/ready handshake and divided by restoring
// long division on their magnitudes, STEP quotient bits per cycle. Signs are
// applied in a single FIXUP cycle. The HI/LO result is held until the consumer
// takes it with out_ready.
module divider_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic             idle_reg;
  logic             sign_reg;
  logic             nega_reg;
  logic             negb_reg;
  logic [WIDTH-1:0] n_reg;      // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] d_reg;      // divisor magnitude
  logic [WIDTH:0]   r_reg;      // partial remainder, one extra bit of headroom
  logic [CW-1:0]    cnt_reg;    // CALC cycles still to run

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] n_step;

  // A pending cancel blocks acceptance in the same cycle.
  assign in_ready = idle_reg & ~cancel;
  assign accept   = in_valid & in_ready;

  // Negative operands only exist for signed division. Negating 0x8000_0000
  // yields 0x8000_0000, which is the correct unsigned magnitude.
  assign a_neg = sign & srca[WIDTH-1];
  assign b_neg = sign & srcb[WIDTH-1];
  assign mag_a = a_neg ? -srca : srca;
  assign mag_b = b_neg ? -srcb : srcb;

  // STEP restoring-division iterations, MSB first. Quotient bits shift into
  // the bottom of n as the dividend bits shift out of the top.
  always_comb begin
    r_step = r_reg;
    n_step = n_reg;
    for (int k = 0; k < STEP; k++) begin
      r_step = {r_step[WIDTH-1:0], n_step[WIDTH-1]};
      n_step = {n_step[WIDTH-2:0], 1'b0};
      if (r_step >= {1'b0, d_reg}) begin
        r_step    = r_step - {1'b0, d_reg};
        n_step[0] = 1'b1;
      end
    end
  end

  // Control FSM and datapath registers; cancel overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idle_reg  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      sign_reg  <= 1'b0;
      nega_reg  <= 1'b0;
      negb_reg  <= 1'b0;
      n_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
    end else if (cancel) begin
      state     <= IDLE;
      idle_reg  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_reg <= sign;
            nega_reg <= a_neg;
            negb_reg <= b_neg;
            n_reg    <= mag_a;
            d_reg    <= mag_b;
            r_reg    <= '0;
            cnt_reg  <= CW'(N);
            idle_reg <= 1'b0;
            if (srcb == '0) begin
              // Divide by zero: skip the iterations, report all-ones / dividend.
              state     <= DONE;
              out_valid <= 1'b1;
              lo        <= '1;
              hi        <= srca;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_reg   <= r_step;
          n_reg   <= n_step;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          // Truncation toward zero: quotient negative when signs differ,
          // remainder follows the dividend's sign.
          lo        <= (sign_reg && (nega_reg != negb_reg)) ? -n_reg : n_reg;
          hi        <= (sign_reg && nega_reg) ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
          busy      <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            idle_reg  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          idle_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Testbench for divider_seq_ctrl. Three instances (STEP 1, 2, 4) share
// stimulus; each has its own scoreboard queue filled on acceptance and
// drained when that instance hands over a result.
module tb_divider_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sign;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        cancel1;
  logic        out_ready;

  logic        rdy1, busy1, ov1;
  logic [31:0] hi1, lo1;
  logic        rdy2, busy2, ov2;
  logic [31:0] hi2, lo2;
  logic        rdy4, busy4, ov4;
  logic [31:0] hi4, lo4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [63:0] q4[$];

  always #5 clk = ~clk;

  divider_seq_ctrl #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .sign(sign),
    .srca(srca), .srcb(srcb), .cancel(cancel1), .busy(busy1), .out_valid(ov1),
    .out_ready(out_ready), .hi(hi1), .lo(lo1));

  divider_seq_ctrl #(.WIDTH(32), .STEP(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .sign(sign),
    .srca(srca), .srcb(srcb), .cancel(1'b0), .busy(busy2), .out_valid(ov2),
    .out_ready(out_ready), .hi(hi2), .lo(lo2));

  divider_seq_ctrl #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .sign(sign),
    .srca(srca), .srcb(srcb), .cancel(1'b0), .busy(busy4), .out_valid(ov4),
    .out_ready(out_ready), .hi(hi4), .lo(lo4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from the language's own / and % operators.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] as;
    logic signed [31:0] bs;
    logic [31:0] q;
    logic [31:0] r;
    as = a;
    bs = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = as / bs;
        r = as % bs;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Scoreboard drains, one per instance, on each completed handshake.
  always @(negedge clk) begin
    if (!rst && ov1 && out_ready) begin
      logic [63:0] e;
      chk("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("dut1_hi", hi1, e[63:32]);
        chk("dut1_lo", lo1, e[31:0]);
        $display("txn dut1 hi=%h lo=%h exp_hi=%h exp_lo=%h", hi1, lo1, e[63:32], e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && out_ready) begin
      logic [63:0] e;
      chk("sb2_pending", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("dut2_hi", hi2, e[63:32]);
        chk("dut2_lo", lo2, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && out_ready) begin
      logic [63:0] e;
      chk("sb4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("dut4_hi", hi4, e[63:32]);
        chk("dut4_lo", lo4, e[31:0]);
      end
    end
  end

  // Called just after a negedge; presents one request across the accept edge.
  task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    in_valid = 1'b1;
    sign     = sg;
    srca     = a;
    srcb     = b;
    #1;
    e = model(sg, a, b);
    if (rdy1) q1.push_back(e);
    if (rdy2) q2.push_back(e);
    if (rdy4) q4.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle_all();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(rdy1 && rdy2 && rdy4) && t < 300);
    if (!(rdy1 && rdy2 && rdy4)) chk("idle_timeout", {29'd0, rdy1, rdy2, rdy4}, 32'd7);
  endtask

  task automatic wait_ov1();
    int k;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (ov1) break;
    end
    if (!ov1) chk("ov1_timeout", {31'd0, ov1}, 32'd1);
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    wait_idle_all();
    drive(sg, a, b);
    wait_ov1();
  endtask

  initial begin
    int first;
    int busy_cnt;
    logic ov_seen;
    logic sg;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; in_valid = 1'b0; sign = 1'b0; srca = '0; srcb = '0;
    cancel1 = 1'b0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_out_valid", {31'd0, ov1}, 32'd0);
    chk("rst_hi", hi1, 32'd0);
    chk("rst_lo", lo1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100/7 with latency and busy window
    wait_idle_all();
    drive(1'b0, 32'd100, 32'd7);
    first = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_at_T+1", {31'd0, busy1}, 32'd1);
      if (ov1) begin
        first = k;
        break;
      end
      if (busy1) busy_cnt++;
    end
    chk("divu_latency", first, 32'd34);
    chk("busy_cycles", busy_cnt, 32'd33);
    chk("busy_in_done", {31'd0, busy1}, 32'd0);
    chk("in_ready_in_done", {31'd0, rdy1}, 32'd0);

    // Signed rules, overflow, unsigned full-range
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);

    // Divide by zero: result one cycle after accept, no busy
    wait_idle_all();
    drive(1'b0, 32'd5, 32'd0);
    @(negedge clk);
    chk("dz_out_valid_T+1", {31'd0, ov1}, 32'd1);
    chk("dz_busy", {31'd0, busy1}, 32'd0);
    chk("dz_lo", lo1, 32'hFFFF_FFFF);
    chk("dz_hi", hi1, 32'd5);

    // Cancel at T+10 on the STEP=1 instance, then a fresh request at T+11
    wait_idle_all();
    drive(1'b1, 32'd1234567, 32'd89);
    ov_seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ov1) ov_seen = 1'b1;
    end
    cancel1 = 1'b1;
    #1;
    chk("cancel_in_ready", {31'd0, rdy1}, 32'd0);
    @(posedge clk);
    #1;
    cancel1 = 1'b0;
    void'(q1.pop_back());
    @(negedge clk);
    chk("cancel_no_out_valid", {31'd0, ov_seen | ov1}, 32'd0);
    chk("cancel_busy", {31'd0, busy1}, 32'd0);
    chk("cancel_in_ready_T+11", {31'd0, rdy1}, 32'd1);
    chk("cancel_hi_kept", hi1, 32'd5);
    chk("cancel_lo_kept", lo1, 32'hFFFF_FFFF);
    drive(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_ov1();

    // Cancel together with in_valid in IDLE: not accepted
    wait_idle_all();
    cancel1 = 1'b1;
    #1;
    chk("cancel_idle_in_ready", {31'd0, rdy1}, 32'd0);
    drive(1'b0, 32'd50, 32'd3);
    cancel1 = 1'b0;
    @(negedge clk);
    chk("cancel_idle_busy", {31'd0, busy1}, 32'd0);
    chk("cancel_idle_out_valid", {31'd0, ov1}, 32'd0);

    // Consumer back-pressure: result held while out_ready is low
    wait_idle_all();
    out_ready = 1'b0;
    drive(1'b0, 32'd1000, 32'd3);
    wait_ov1();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, ov1}, 32'd1);
      chk("hold_lo", lo1, 32'd333);
      chk("hold_hi", hi1, 32'd1);
      chk("hold_in_ready", {31'd0, rdy1}, 32'd0);
    end
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("released_out_valid", {31'd0, ov1}, 32'd0);
    chk("released_lo_kept", lo1, 32'd333);

    // Reset in the middle of CALC
    wait_idle_all();
    drive(1'b1, 32'd999999, 32'd13);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    chk("midrst_out_valid", {31'd0, ov1}, 32'd0);
    chk("midrst_hi", hi1, 32'd0);
    chk("midrst_lo", lo1, 32'd0);
    chk("midrst_in_ready", {31'd0, rdy1}, 32'd1);
    q1.delete();
    q2.delete();
    q4.delete();
    @(negedge clk);
    rst = 1'b0;

    // Random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(sg, a, b);
    end

    wait_idle_all();
    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
